channel_accumulator: RTL and testbench

Successor to the fixed 8-channel accumulator in the conv datapath. Sums a run-time-programmable number of signed partial sums per output pixel, across input channels, onto a preloaded bias. Applies optional ReLU and saturation, then presents one result per group on a valid/ready output. Sits between the PE array partial-sum output and the output-feature-map writer, and sustains one input beat per cycle including group boundaries.

---
 rtl/accumulator_pkg.sv | 29 ++
 rtl/acc_post_proc.sv | 42 ++++
 rtl/channel_accumulator.sv | 169 ++++++++++++++++
 tb/tb_channel_accumulator.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_pkg.sv
// Shared types and helpers for the channel accumulator: FSM state encoding,
// default output range limits and a width-generic sign-extension helper.
package accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    // Working width of the sign-extension helper; callers cast the result
    // down to their own accumulator width.
    localparam int SEXT_W = 128;

    localparam int DEF_OUT_WIDTH = 32;
    localparam logic signed [63:0] OUT_MAX = (64'sd1 <<< (DEF_OUT_WIDTH - 1)) - 64'sd1;
    localparam logic signed [63:0] OUT_MIN = -(64'sd1 <<< (DEF_OUT_WIDTH - 1));

    // Replicates bit w-1 of v into every bit above it.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int w);
        logic [SEXT_W-1:0] r;
        r = v;
        for (int i = 0; i < SEXT_W; i++) begin
            if (i >= w) r[i] = v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_post_proc.sv
// Combinational post-processing of a final group sum: optional ReLU, then
// overflow detection against the signed output range and clamp or truncate.
module acc_post_proc
    import accumulator_pkg::*;
#(
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 32
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic                        relu_en,
    input  logic                        sat_en,
    output logic        [OUT_WIDTH-1:0] data,
    output logic                        sat
);

    // Output range limits sign-extended to accumulator width for comparison.
    localparam logic signed [ACC_WIDTH-1:0] MAX_A =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_A =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] val;
    logic                        over_hi;
    logic                        over_lo;

    always_comb begin
        val = acc;
        if (relu_en && acc[ACC_WIDTH-1]) begin
            val = '0;
        end
        over_hi = (val > MAX_A);
        over_lo = (val < MIN_A);
        sat     = over_hi || over_lo;
        data    = val[OUT_WIDTH-1:0];
        if (sat_en && over_hi) begin
            data = MAX_A[OUT_WIDTH-1:0];
        end else if (sat_en && over_lo) begin
            data = MIN_A[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/channel_accumulator.sv
// Sums a programmable number of signed partial sums onto a bias per group and
// presents one post-processed result per group on a valid/ready output.
module channel_accumulator
    import accumulator_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int OUT_WIDTH   = 32,
    parameter int ACC_WIDTH   = 40,
    parameter int MAX_CHANNEL = 64,
    parameter int CNT_WIDTH   = $clog2(MAX_CHANNEL + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_WIDTH-1:0]  cfg_n_channel,
    input  logic                  cfg_relu_en,
    input  logic                  cfg_sat_en,
    input  logic [DATA_WIDTH-1:0] bias_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic [CNT_WIDTH-1:0]  current_no_channel,
    output logic                  busy
);

    // Valid/ready: a beat or result moves on the rising edge where valid and
    // ready are both high; a held result keeps data and sat stable until taken.

    acc_state_t state;
    acc_state_t state_nx;

    logic [CNT_WIDTH-1:0]        n_q;
    logic [CNT_WIDTH-1:0]        n_new;
    logic [CNT_WIDTH-1:0]        cnt;
    logic                        relu_q;
    logic                        sat_q;
    logic                        relu_use;
    logic                        sat_use;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_nx;
    logic signed [ACC_WIDTH-1:0] bias_x;
    logic signed [ACC_WIDTH-1:0] data_x;
    logic [OUT_WIDTH-1:0]        pp_data;
    logic                        pp_sat;
    logic                        beat;
    logic                        start;
    logic                        finish;
    logic                        out_fire;

    assign bias_x = ACC_WIDTH'(sext(SEXT_W'(bias_in), DATA_WIDTH));
    assign data_x = ACC_WIDTH'(sext(SEXT_W'(in_data), DATA_WIDTH));

    // Zero means a single beat; anything above the supported maximum clamps.
    always_comb begin
        n_new = cfg_n_channel;
        if (cfg_n_channel == '0) begin
            n_new = CNT_WIDTH'(1);
        end else if (cfg_n_channel > CNT_WIDTH'(MAX_CHANNEL)) begin
            n_new = CNT_WIDTH'(MAX_CHANNEL);
        end
    end

    // A beat outside ACCUM always opens a new group (from IDLE, or from HOLD
    // where a beat implies the pending result is leaving the same cycle).
    always_comb begin
        beat     = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        start    = beat && (state != ACCUM);
        finish   = start ? (n_new == CNT_WIDTH'(1))
                         : ((state == ACCUM) && beat && ((cnt + CNT_WIDTH'(1)) == n_q));
        relu_use = start ? cfg_relu_en : relu_q;
        sat_use  = start ? cfg_sat_en  : sat_q;
        acc_nx   = start ? (bias_x + data_x) : (acc + data_x);
    end

    acc_post_proc #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_post_proc (
        .acc     (acc_nx),
        .relu_en (relu_use),
        .sat_en  (sat_use),
        .data    (pp_data),
        .sat     (pp_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = finish ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (finish) state_nx = HOLD;
            end
            HOLD: begin
                if (start) begin
                    state_nx = finish ? HOLD : ACCUM;
                end else if (out_fire) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:  in_ready = !rst;
            ACCUM: begin
                in_ready = !rst;
                busy     = 1'b1;
            end
            HOLD: begin
                in_ready  = !rst && out_ready;
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            n_q      <= '0;
            relu_q   <= 1'b0;
            sat_q    <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            if (start) begin
                n_q    <= n_new;
                relu_q <= cfg_relu_en;
                sat_q  <= cfg_sat_en;
                acc    <= acc_nx;
                cnt    <= CNT_WIDTH'(1);
            end else if ((state == ACCUM) && beat) begin
                acc <= acc_nx;
                cnt <= cnt + CNT_WIDTH'(1);
            end else if ((state == HOLD) && out_fire) begin
                cnt <= '0;
            end
            // The result register only loads on the edge that enters HOLD.
            if (finish) begin
                out_data <= pp_data;
                out_sat  <= pp_sat;
            end
        end
    end

    assign current_no_channel = cnt;

endmodule

// File: tb/tb_channel_accumulator.sv
// Self-checking bench for channel_accumulator: directed scenarios plus random
// groups compared against an arithmetic reference model.
module tb_channel_accumulator;

    logic        clk;
    logic        rst;
    logic [6:0]  cfg_n_channel;
    logic        cfg_relu_en;
    logic        cfg_sat_en;
    logic [31:0] bias_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic [6:0]  current_no_channel;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int beats_sent   = 0;
    int beats_acc    = 0;
    int stalls       = 0;
    bit rand_ready   = 0;

    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    logic [31:0] beat_q[$];

    channel_accumulator dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_n_channel      (cfg_n_channel),
        .cfg_relu_en        (cfg_relu_en),
        .cfg_sat_en         (cfg_sat_en),
        .bias_in            (bias_in),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_sat            (out_sat),
        .current_no_channel (current_no_channel),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) beats_acc++;
        if (!rst && out_valid && out_ready) got_q.push_back({out_sat, out_data});
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: 40-bit wrapping sum, then ReLU, range check, clamp/truncate.
    function automatic logic [32:0] ref_out(input longint sum, input bit relu, input bit sat);
        longint      v;
        bit          ovf;
        logic [31:0] d;
        v = (sum <<< 24) >>> 24;
        if (relu && v < 0) v = 0;
        ovf = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        d = v[31:0];
        if (sat && v > 64'sd2147483647) d = 32'h7FFF_FFFF;
        else if (sat && v < -64'sd2147483648) d = 32'h8000_0000;
        return {ovf, d};
    endfunction

    task automatic drive_beat(input logic [31:0] d);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        if (!in_ready) stalls++;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL beat_timeout: in_ready stayed 0 for %0d cycles", waited);
        end
        @(posedge clk);
        #1;
        beats_sent++;
    endtask

    task automatic send_group(input int ncfg, input logic [31:0] bias, input bit relu,
                              input bit sat, input int gap_max, output logic [32:0] e_out);
        int          n;
        int          g;
        longint      sum;
        logic [31:0] d;
        n   = (ncfg == 0) ? 1 : ((ncfg > 64) ? 64 : ncfg);
        sum = longint'($signed(bias));
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gap_max > 0) begin
                g = $urandom_range(0, gap_max);
                if (g > 0) begin
                    in_valid = 1'b0;
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            if (i == 0) begin
                cfg_n_channel = 7'(ncfg);
                cfg_relu_en   = relu;
                cfg_sat_en    = sat;
                bias_in       = bias;
            end else begin
                cfg_n_channel = 7'($urandom_range(0, 127));
                cfg_relu_en   = 1'($urandom);
                cfg_sat_en    = 1'($urandom);
                bias_in       = $urandom;
            end
            d = (beat_q.size() > 0) ? beat_q.pop_front() : $urandom;
            sum += longint'($signed(d));
            drive_beat(d);
        end
        e_out = ref_out(sum, relu, sat);
    endtask

    task automatic wait_results();
        int k;
        k = 0;
        in_valid = 1'b0;
        while (got_q.size() < exp_q.size() && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        tests_run++;
        if (out_sat !== 1'b0) begin tests_failed++; $display("FAIL reset_out_sat: got %b expected 0", out_sat); end
        tests_run++;
        if (current_no_channel !== 7'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", current_no_channel); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_sum();
        logic [32:0] e;
        logic [32:0] g;
        out_ready = 1'b1;
        cfg_n_channel = 7'd4;
        cfg_relu_en = 1'b0;
        cfg_sat_en = 1'b1;
        bias_in = 32'd10;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 32'(i + 1);
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_in_ready beat %0d: got %b expected 1", i, in_ready); end
            @(posedge clk);
            #1;
            tests_run++;
            if (current_no_channel !== 7'(i + 1)) begin tests_failed++; $display("FAIL basic_count beat %0d: got %0d expected %0d", i, current_no_channel, i + 1); end
            tests_run++;
            if (out_valid !== (i == 3)) begin tests_failed++; $display("FAIL basic_latency beat %0d: out_valid got %b expected %b", i, out_valid, i == 3); end
        end
        in_valid = 1'b0;
        tests_run++;
        if ({out_sat, out_data} !== {1'b0, 32'd20}) begin tests_failed++; $display("FAIL basic_sum: got sat=%b data=%0d expected sat=0 data=20", out_sat, out_data); end
        exp_q.push_back({1'b0, 32'd20});
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || current_no_channel !== 7'd0) begin tests_failed++; $display("FAIL basic_return_idle: out_valid=%b count=%0d expected 0 and 0", out_valid, current_no_channel); end
        wait_results();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 33'h0_DEAD_0000;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL basic_result: got %h expected %h", g, e); end
        end
        tests_run++;
        if (got_q.size() != 0) begin tests_failed++; $display("FAIL basic_extra: got %0d extra results expected 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_backpressure();
        logic [32:0] e;
        logic [32:0] g;
        int          b0;
        b0 = beats_acc;
        out_ready = 1'b0;
        beat_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        send_group(4, 32'd10, 1'b0, 1'b0, 0, e);
        exp_q.push_back({1'b0, 32'd20});
        cfg_n_channel = 7'd2;
        cfg_relu_en = 1'b0;
        cfg_sat_en = 1'b0;
        bias_in = 32'd0;
        in_data = 32'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || {out_sat, out_data} !== {1'b0, 32'd20}) begin tests_failed++; $display("FAIL bp_hold cycle %0d: valid=%b data=%0d expected valid=1 data=20", i, out_valid, out_data); end
            tests_run++;
            if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", i, in_ready); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        beat_q = '{32'd5, 32'd6};
        send_group(2, 32'd0, 1'b0, 1'b0, 0, e);
        exp_q.push_back({1'b0, 32'd11});
        wait_results();
        tests_run++;
        if (beats_acc - b0 != 6) begin tests_failed++; $display("FAIL bp_beat_count: got %0d expected 6", beats_acc - b0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 33'h0_DEAD_0000;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL bp_result: got %h expected %h", g, e); end
        end
        tests_run++;
        if (got_q.size() != 0) begin tests_failed++; $display("FAIL bp_extra: got %0d extra results expected 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_relu_sat();
        logic [32:0] e;
        logic [32:0] g;
        out_ready = 1'b1;
        beat_q = '{-32'sd5, 32'd2};
        send_group(2, 32'd0, 1'b1, 1'b0, 0, e);
        exp_q.push_back({1'b0, 32'h0000_0000});
        beat_q = '{-32'sd5, 32'd2};
        send_group(2, 32'd0, 1'b0, 1'b0, 0, e);
        exp_q.push_back({1'b0, 32'hFFFF_FFFD});
        beat_q = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        send_group(2, 32'd0, 1'b0, 1'b1, 0, e);
        exp_q.push_back({1'b1, 32'h7FFF_FFFF});
        beat_q = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        send_group(2, 32'd0, 1'b0, 1'b0, 0, e);
        exp_q.push_back({1'b1, 32'hFFFF_FFFE});
        beat_q = '{32'h8000_0000, 32'h8000_0000};
        send_group(2, 32'd0, 1'b0, 1'b1, 0, e);
        exp_q.push_back({1'b1, 32'h8000_0000});
        wait_results();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 33'h0_DEAD_0000;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL relu_sat_result %0d: got %h expected %h", i, g, e); end
        end
        tests_run++;
        if (got_q.size() != 0) begin tests_failed++; $display("FAIL relu_sat_extra: got %0d extra results expected 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_single_channel();
        logic [32:0] e;
        logic [32:0] g;
        out_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            send_group((i < 8) ? 0 : 1, $urandom, 1'b0, 1'($urandom), 0, e);
            exp_q.push_back(e);
        end
        wait_results();
        tests_run++;
        if (stalls != 0) begin tests_failed++; $display("FAIL single_stream_stalls: got %0d expected 0", stalls); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 33'h0_DEAD_0000;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL single_result %0d: got %h expected %h", i, g, e); end
        end
        tests_run++;
        if (got_q.size() != 0) begin tests_failed++; $display("FAIL single_extra: got %0d extra results expected 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_reset_mid_group();
        logic [32:0] e;
        logic [32:0] g;
        out_ready = 1'b1;
        cfg_n_channel = 7'd4;
        cfg_relu_en = 1'b0;
        cfg_sat_en = 1'b0;
        bias_in = 32'd0;
        drive_beat(32'd100);
        drive_beat(32'd200);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || current_no_channel !== 7'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset: valid=%b count=%0d busy=%b expected 0 0 0", out_valid, current_no_channel, busy); end
        rst = 1'b0;
        beat_q = '{32'd1, 32'd1, 32'd1, 32'd1};
        send_group(4, 32'd0, 1'b0, 1'b1, 0, e);
        exp_q.push_back({1'b0, 32'd4});
        wait_results();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 33'h0_DEAD_0000;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL mid_reset_result: got %h expected %h", g, e); end
        end
        tests_run++;
        if (got_q.size() != 0) begin tests_failed++; $display("FAIL mid_reset_extra: got %0d extra results expected 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_random();
        logic [32:0] e;
        logic [32:0] g;
        int          ncfg;
        int          sel;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            ncfg = (sel == 0) ? 64 : ((sel == 1) ? $urandom_range(65, 127) : $urandom_range(0, 8));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_group(ncfg, $urandom, 1'($urandom), 1'($urandom), 2, e);
            exp_q.push_back(e);
        end
        in_valid = 1'b0;
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        wait_results();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 33'h0_DEAD_0000;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL random_result %0d: got %h expected %h", i, g, e); end
        end
        tests_run++;
        if (got_q.size() != 0) begin tests_failed++; $display("FAIL random_extra: got %0d extra results expected 0", got_q.size()); got_q.delete(); end
    endtask

    initial begin
        rst = 1'b1;
        cfg_n_channel = 7'd0;
        cfg_relu_en = 1'b0;
        cfg_sat_en = 1'b0;
        bias_in = 32'd0;
        in_valid = 1'b0;
        in_data = 32'd0;
        out_ready = 1'b1;
        test_reset();
        test_basic_sum();
        test_backpressure();
        test_relu_sat();
        test_single_channel();
        test_reset_mid_group();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
